e_mul_div_unit: RTL and testbench

//   E-stage multiply/divide unit owning the HI/LO registers. Executes mult/multu/div/divu

---
 rtl/e_mul_div_unit.sv | 109 ++++++++++
 tb/tb_e_mul_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/e_mul_div_unit.sv
// E-stage multiply/divide unit owning HI/LO: multi-cycle mult/div with a
// pending result committed at the end of the latency, single-cycle mthi/mtlo.
module e_mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDU_Op,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  output logic        E_HILObusy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [3:0]  cnt;
  logic [31:0] t_hi;
  logic [31:0] t_lo;
  logic        t_we;
  logic        start;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] abs_b_safe;
  logic [31:0] div_b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  assign start      = (MDU_Op >= OP_MULT) && (MDU_Op <= OP_DIVU) && (cnt == 4'd0);
  assign E_HILObusy = start || (cnt != 4'd0);

  assign prod_s = $signed({{32{MDU_A[31]}}, MDU_A}) * $signed({{32{MDU_B[31]}}, MDU_B});
  assign prod_u = {32'd0, MDU_A} * {32'd0, MDU_B};

  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly;
  // the zero-divisor guard only keeps the datapath defined, nothing commits then.
  assign abs_a      = MDU_A[31] ? (~MDU_A + 32'd1) : MDU_A;
  assign abs_b      = MDU_B[31] ? (~MDU_B + 32'd1) : MDU_B;
  assign abs_b_safe = (MDU_B == 32'd0) ? 32'd1 : abs_b;
  assign div_b_safe = (MDU_B == 32'd0) ? 32'd1 : MDU_B;
  assign q_mag      = abs_a / abs_b_safe;
  assign r_mag      = abs_a % abs_b_safe;
  assign quot_s     = (MDU_A[31] ^ MDU_B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s      = MDU_A[31] ? (~r_mag + 32'd1) : r_mag;
  assign quot_u     = MDU_A / div_b_safe;
  assign rem_u      = MDU_A % div_b_safe;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      t_hi <= 32'd0;
      t_lo <= 32'd0;
      t_we <= 1'b0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else if (cnt != 4'd0) begin
      // Ops arriving while busy are ignored; commit happens on the last count.
      cnt <= cnt - 4'd1;
      if ((cnt == 4'd1) && t_we) begin
        HI <= t_hi;
        LO <= t_lo;
      end
    end else begin
      case (MDU_Op)
        OP_MULT: begin
          {t_hi, t_lo} <= prod_s;
          t_we         <= 1'b1;
          cnt          <= 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {t_hi, t_lo} <= prod_u;
          t_we         <= 1'b1;
          cnt          <= 4'(MULT_CYCLES);
        end
        OP_DIV: begin
          t_hi <= rem_s;
          t_lo <= quot_s;
          t_we <= (MDU_B != 32'd0);
          cnt  <= 4'(DIV_CYCLES);
        end
        OP_DIVU: begin
          t_hi <= rem_u;
          t_lo <= quot_u;
          t_we <= (MDU_B != 32'd0);
          cnt  <= 4'(DIV_CYCLES);
        end
        OP_MTHI: HI <= MDU_A;
        OP_MTLO: LO <= MDU_A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mul_div_unit.sv
// Directed and randomized bench for e_mul_div_unit, checked against an
// arithmetic reference model of HI/LO and operation latency.
module tb_e_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  MDU_Op;
  logic [31:0] MDU_A;
  logic [31:0] MDU_B;
  logic        E_HILObusy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .MDU_Op     (MDU_Op),
    .MDU_A      (MDU_A),
    .MDU_B      (MDU_B),
    .E_HILObusy (E_HILObusy),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: HI/LO after an op plus its latency, from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint sa;
    longint sb;
    longint sp;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    case (op)
      3'd1: begin
        sp = sa * sb;
        h = sp[63:32];
        l = sp[31:0];
        lat = 5;
      end
      3'd2: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32];
        l = up[31:0];
        lat = 5;
      end
      3'd3: begin
        lat = 10;
        if (b != 32'd0) begin
          sp = sa / sb;
          l = sp[31:0];
          sp = sa % sb;
          h = sp[31:0];
        end
      end
      3'd4: begin
        lat = 10;
        if (b != 32'd0) begin
          l = a / b;
          h = a % b;
        end
      end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDU_Op = op;
    MDU_A  = a;
    MDU_B  = b;
  endtask

  task automatic checkOutput(input string tag, input logic exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    #1;
    checks++;
    assert (E_HILObusy === exp_busy) else begin
      errors++;
      $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, E_HILObusy, exp_busy);
    end
    checks++;
    assert (HI === exp_hi) else begin
      errors++;
      $error("[TB] FAIL %s HI observed=%h expected=%h", tag, HI, exp_hi);
    end
    checks++;
    assert (LO === exp_lo) else begin
      errors++;
      $error("[TB] FAIL %s LO observed=%h expected=%h", tag, LO, exp_lo);
    end
  endtask

  // Issues one op and follows it to completion; intr_k>0 injects a MULT that
  // many cycles after start, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int intr_k);
    logic [31:0] nh;
    logic [31:0] nl;
    int lat;
    nh = m_hi;
    nl = m_lo;
    model(op, a, b, nh, nl, lat);
    applyStimulus(op, a, b);
    checkOutput({tag, ":start"}, lat != 0, m_hi, m_lo);
    for (int k = 1; k <= lat; k++) begin
      if (k == intr_k) applyStimulus(3'd1, $urandom, $urandom);
      else applyStimulus(3'd0, $urandom, $urandom);
      checkOutput($sformatf("%s:run%0d", tag, k), 1'b1, m_hi, m_lo);
    end
    applyStimulus(3'd0, 32'd0, 32'd0);
    m_hi = nh;
    m_lo = nl;
    checkOutput({tag, ":done"}, 1'b0, m_hi, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    checks = 0;
    errors = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    reset  = 1'b1;
    MDU_Op = 3'd0;
    MDU_A  = 32'd0;
    MDU_B  = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset", 1'b0, 32'd0, 32'd0);

    run_op("mult_neg", 3'd1, 32'hFFFFFFFF, 32'd2, 0);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 0);
    run_op("divu", 3'd4, 32'd7, 32'd2, 0);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0);

    applyStimulus(3'd5, 32'h12345678, 32'd0);
    checkOutput("mthi", 1'b0, m_hi, m_lo);
    m_hi = 32'h12345678;
    applyStimulus(3'd6, 32'h9ABCDEF0, 32'd0);
    checkOutput("mtlo", 1'b0, m_hi, m_lo);
    m_lo = 32'h9ABCDEF0;
    applyStimulus(3'd0, 32'd0, 32'd0);
    checkOutput("mt_after", 1'b0, m_hi, m_lo);

    run_op("pre_hi", 3'd5, 32'hAA, 32'd0, 0);
    run_op("pre_lo", 3'd6, 32'hBB, 32'd0, 0);
    run_op("div_zero", 3'd3, 32'd1234, 32'd0, 3);
    run_op("divu_zero", 3'd4, 32'd99, 32'd0, 0);
    run_op("reserved", 3'd7, 32'h55555555, 32'd1, 0);

    // Reset two cycles into a MULT aborts it with no later commit.
    applyStimulus(3'd1, 32'd3, 32'd4);
    checkOutput("rst_start", 1'b1, m_hi, m_lo);
    applyStimulus(3'd0, 32'd0, 32'd0);
    checkOutput("rst_t1", 1'b1, m_hi, m_lo);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int k = 3; k <= 7; k++) begin
      checkOutput($sformatf("rst_t%0d", k), 1'b0, m_hi, m_lo);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, (i % 3 == 0) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
